// File: rtl/snn_image_loader.sv
// snn_image_loader: receives a packed binary image byte-by-byte, holds it in a
// pixel buffer served to the SNN core's read port, kicks the core, and returns
// the classified digit as an ASCII byte on the transmit handshake.
// Note: rst_n is an active-high synchronous reset despite its name.
module snn_image_loader #(
  parameter int NUM_PIXELS  = 784,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [9:0] addr_input_unit,
  output logic       q_input,
  output logic       start,
  input  logic       done,
  input  logic [3:0] digit,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int IDLE_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC - 1);
  // One bit wider than the address so that 1024 pixels would still compare correctly
  localparam logic [10:0]       PIX_LIMIT = 11'(NUM_PIXELS);

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    KICK      = 2'd1,
    WAIT_DONE = 2'd2,
    SEND      = 2'd3
  } state_t;

  state_t              state_reg;
  logic [BYTE_W-1:0]   byte_cnt_reg;
  logic [IDLE_W-1:0]   idle_cnt_reg;
  logic                rx_ready_reg;
  logic                start_reg;
  logic                tx_valid_reg;
  logic [7:0]          tx_data_reg;
  logic                busy_reg;
  logic                q_input_reg;

  logic [NUM_PIXELS-1:0] pix_flat;

  logic                accept;
  logic                timeout_fire;
  logic [BYTE_W-1:0]   wr_idx;
  logic                last_byte;

  // Decode the byte handshake and the mid-frame timeout for this cycle
  always_comb begin
    accept       = 1'b0;
    timeout_fire = 1'b0;
    wr_idx       = byte_cnt_reg;
    last_byte    = 1'b0;
    if (state_reg == LOAD) begin
      accept       = rx_valid && rx_ready_reg;
      timeout_fire = (byte_cnt_reg != '0) && (idle_cnt_reg == IDLE_MAX);
    end
    // A byte landing on the timeout cycle starts a fresh frame at byte 0
    if (timeout_fire) begin
      wr_idx = '0;
    end
    last_byte = (wr_idx == LAST_BYTE);
  end

  // Frame sequencing: load bytes, kick the core, wait for its result, send it
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg    <= LOAD;
      byte_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      rx_ready_reg <= 1'b1;
      start_reg    <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      busy_reg     <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (accept) begin
            idle_cnt_reg <= '0;
            if (last_byte) begin
              byte_cnt_reg <= '0;
              state_reg    <= KICK;
              start_reg    <= 1'b1;
              rx_ready_reg <= 1'b0;
              busy_reg     <= 1'b1;
            end else begin
              byte_cnt_reg <= wr_idx + BYTE_W'(1);
            end
          end else if (timeout_fire) begin
            // Drop the partial frame; buffer contents are kept as they are
            byte_cnt_reg <= '0;
            idle_cnt_reg <= '0;
          end else if (byte_cnt_reg != '0) begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
          end else begin
            idle_cnt_reg <= '0;
          end
        end
        KICK: begin
          state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            // Digits above 9 pass straight through the ASCII offset
            tx_data_reg  <= 8'h30 + {4'h0, digit};
            tx_valid_reg <= 1'b1;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= LOAD;
            rx_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg    <= LOAD;
          byte_cnt_reg <= '0;
          idle_cnt_reg <= '0;
          rx_ready_reg <= 1'b1;
          tx_valid_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Pixel buffer, one register lane per received byte
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;

      // Capture this lane when the active write index selects it
      always_ff @(posedge clk) begin
        if (rst_n) begin
          byte_reg <= 8'h00;
        end else if (accept && (wr_idx == BYTE_W'(gi))) begin
          byte_reg <= rx_data;
        end
      end

      assign pix_flat[8*gi +: 8] = byte_reg;
    end
  endgenerate

  // Registered pixel read port; out-of-range addresses read as zero
  always_ff @(posedge clk) begin
    if (rst_n) begin
      q_input_reg <= 1'b0;
    end else if ({1'b0, addr_input_unit} < PIX_LIMIT) begin
      q_input_reg <= pix_flat[addr_input_unit];
    end else begin
      q_input_reg <= 1'b0;
    end
  end

  assign rx_ready = rx_ready_reg;
  assign start    = start_reg;
  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign busy     = busy_reg;
  assign q_input  = q_input_reg;

endmodule

// File: tb/tb_snn_image_loader.sv
// Scoreboard bench for snn_image_loader: stimulus pushes expected start cycles,
// pixel reads and result bytes into queues; a negedge monitor pops and compares.
module tb_snn_image_loader;

  localparam int NPIX = 784;
  localparam int NB   = NPIX / 8;
  localparam int TOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [9:0] addr_input_unit = 10'd0;
  logic       q_input;
  logic       start;
  logic       done = 1'b0;
  logic [3:0] digit = 4'h0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;

  snn_image_loader #(
    .NUM_PIXELS (NPIX),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .addr_input_unit(addr_input_unit),
    .q_input        (q_input),
    .start          (start),
    .done           (done),
    .digit          (digit),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic val; } rd_t;
  typedef struct { logic [7:0] data; int dur; } tx_t;

  int   start_q[$];
  rd_t  rd_q[$];
  tx_t  tx_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the buffer should hold and where the frame stands
  logic [7:0] mem_m [NB];
  int         pos = 0;
  bit         frame_done = 0;
  int         frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_pix(input int a);
    logic [7:0] b;
    if (a >= NPIX) return 1'b0;
    b = mem_m[a / 8];
    return b[a % 8];
  endfunction

  // ---------------- monitor ----------------
  logic prev_txv = 1'b0;
  tx_t  cur_tx;
  int   tx_len = 0;
  rd_t  r_item;

  always @(negedge clk) begin
    if (rst_n) begin
      prev_txv = 1'b0;
    end else begin
      if (start === 1'b1) begin
        chk("start_expected", 32'(start_q.size() != 0), 32'd1);
        if (start_q.size() != 0) chk("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
      end
      while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        r_item = rd_q.pop_front();
        chk("q_input", 32'(q_input), 32'(r_item.val));
      end
      if (tx_valid === 1'b1 && !prev_txv) begin
        chk("tx_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) begin
          cur_tx = tx_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(cur_tx.data));
        end else begin
          cur_tx.data = tx_data;
          cur_tx.dur  = 0;
        end
        tx_len = 1;
      end else if (tx_valid === 1'b1 && prev_txv) begin
        tx_len++;
        chk("tx_data_stable", 32'(tx_data), 32'(cur_tx.data));
      end else if (tx_valid !== 1'b1 && prev_txv) begin
        chk("tx_valid_len", 32'(tx_len), 32'(cur_tx.dur));
        $display("tx byte 0x%02h held valid %0d cycles", cur_tx.data, tx_len);
      end
      prev_txv = (tx_valid === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic reset_dut(input int n);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    done     = 1'b0;
    tx_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    pos = 0;
    frame_done = 0;
  endtask

  // gap = idle cycles since the previous byte; the model restarts the frame
  // when the line has been quiet for TOUT-1 or more cycles mid-frame
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    if (pos != 0 && gap >= TOUT - 1) pos = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    chk("rx_ready_load", 32'(rx_ready), 32'd1);
    mem_m[pos] = b;
    pos++;
    if (pos == NB) begin
      start_q.push_back(cyc + 1);
      pos = 0;
      frame_done = 1;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic readback(input bit hold_rx, input int first, input int last);
    rx_valid = hold_rx;
    for (int a = first; a <= last; a++) begin
      if (hold_rx) rx_data = 8'($urandom);
      addr_input_unit = 10'(a);
      rd_q.push_back('{cyc: cyc + 1, val: exp_pix(a)});
      @(posedge clk);
      #1;
    end
    foreach (rd_q[i]) ;
    addr_input_unit = 10'd800;
    rd_q.push_back('{cyc: cyc + 1, val: exp_pix(800)});
    @(posedge clk);
    #1;
    addr_input_unit = 10'd1023;
    rd_q.push_back('{cyc: cyc + 1, val: exp_pix(1023)});
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic respond(input logic [3:0] dig, input int delay);
    tx_q.push_back('{data: 8'h30 + {4'h0, dig}, dur: delay + 1});
    done  = 1'b1;
    digit = dig;
    @(posedge clk);
    #1;
    done  = 1'b0;
    digit = 4'($urandom);
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("rx_ready_after_send", 32'(rx_ready), 32'd1);
    chk("busy_after_send", 32'(busy), 32'd0);
  endtask

  // Called right after the final byte: one cycle of KICK, then WAIT_DONE
  task automatic finish_frame(input logic [3:0] dig, input int delay);
    @(posedge clk);
    #1;
    chk("rx_ready_wait", 32'(rx_ready), 32'd0);
    chk("busy_wait", 32'(busy), 32'd1);
    readback(1'b1, 0, NPIX - 1);
    respond(dig, delay);
    frames++;
    $display("frame %0d done, digit %0d", frames, dig);
  endtask

  task automatic send_random_frame(input int rare_gaps);
    int gap_tab [10] = '{1, 2, 3, 7, 13, 14, 15, 16, 17, 25};
    int r;
    int g;
    int n = 0;
    frame_done = 0;
    while (!frame_done && n < 3000) begin
      r = $urandom_range(0, 999);
      g = (rare_gaps != 0 && r >= 990) ? gap_tab[r - 990] : 0;
      send_byte(8'($urandom), g);
      n++;
    end
    chk("frame_completed", 32'(frame_done), 32'd1);
  endtask

  initial begin
    // Reset values
    reset_dut(2);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_q_input", 32'(q_input), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Full frame back-to-back, byte i = i; result 7 with a 5-cycle stall
    frame_done = 0;
    for (int i = 0; i < NB; i++) send_byte(8'(i), 0);
    finish_frame(4'd7, 5);

    // done pulsed in LOAD must not produce a result byte
    done  = 1'b1;
    digit = 4'd5;
    @(posedge clk);
    #1;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("tx_valid_load", 32'(tx_valid), 32'd0);

    // Gappy source: 10 bytes, 20 idle cycles, then a full frame of ones
    frame_done = 0;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    send_byte(8'hFF, 20);
    for (int i = 1; i < NB; i++) send_byte(8'hFF, 0);
    chk("frame_ones", 32'(frame_done), 32'd1);
    finish_frame(4'hA, 0);

    // Timeout boundaries: 14 idle keeps the frame, 15 idle restarts it
    frame_done = 0;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 14);
    send_byte(8'($urandom), 15);
    send_byte(8'($urandom), 16);
    while (!frame_done) send_byte(8'($urandom), 0);
    finish_frame(4'($urandom), 2);

    // Reset mid-frame: buffer cleared, next frame starts at byte 0
    frame_done = 0;
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 0);
    reset_dut(1);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    readback(1'b0, 0, 399);
    send_random_frame(0);
    finish_frame(4'($urandom), 1);

    // Randomized frames with rare long gaps
    for (int f = 0; f < 3; f++) begin
      send_random_frame(1);
      finish_frame(4'($urandom), int'($urandom_range(0, 4)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Bound the whole run
  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
